// File: rtl/wt_dcache_rd_arb.sv
// Read/word-write arbiter for the write-through dcache tag/data arrays: NumPorts readers in two
// priority classes with per-class round-robin. Optional low-class starvation guard: WT_DCACHE_RD_ARB_STARVE_GUARD_EN.
module wt_dcache_rd_arb #(
   parameter int unsigned NumPorts    = 3,
   parameter int unsigned IdxWidth    = 8,
   parameter int unsigned OffWidth    = 4,
   parameter int unsigned StarveLimit = 8,
   localparam int unsigned PortW      = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumPorts-1:0]          rd_req_i,
   input  logic [NumPorts-1:0]          rd_prio_i,
   input  logic [NumPorts-1:0]          rd_tag_only_i,
   input  logic [NumPorts*IdxWidth-1:0] rd_idx_i,
   input  logic [NumPorts*OffWidth-1:0] rd_off_i,
   output logic [NumPorts-1:0]          rd_ack_o,
   input  logic                         wr_cl_vld_i,
   input  logic                         wr_req_i,
   output logic                         wr_ack_o,
   output logic                         bank_req_o,
   output logic                         bank_we_o,
   output logic                         bank_tag_only_o,
   output logic [IdxWidth-1:0]          bank_idx_o,
   output logic [OffWidth-1:0]          bank_off_o,
   output logic                         rd_vld_q_o,
   output logic [PortW-1:0]             rd_port_q_o
);

   if (NumPorts < 2 || StarveLimit < 1 || StarveLimit > 255) begin : g_param_chk
      $error("wt_dcache_rd_arb: NumPorts must be >= 2 and StarveLimit in 1..255");
   end

   logic [PortW-1:0]    rr_hi_q, rr_hi_d, rr_lo_q, rr_lo_d;
   logic                rd_vld_q, rd_vld_d;
   logic [PortW-1:0]    rd_port_q, rd_port_d;
   logic [NumPorts-1:0] hi_req, lo_req, cls_req;
   logic [PortW-1:0]    ptr, cand, gnt_idx;
   logic                force_lo, use_lo, found, grant;

   // (base + step) mod NumPorts, valid for step < NumPorts
   function automatic logic [PortW-1:0] wrap_inc(input logic [PortW-1:0] base, input int unsigned step);
      int unsigned sum;
      sum = 32'(base) + step;
      if (sum >= NumPorts) sum = sum - NumPorts;
      return sum[PortW-1:0];
   endfunction

`ifdef WT_DCACHE_RD_ARB_STARVE_GUARD_EN
   logic [7:0] starve_cnt_q, starve_cnt_d;

   assign force_lo = (starve_cnt_q == 8'(StarveLimit)) & (|lo_req);

   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (grant && use_lo) begin
         starve_cnt_d = '0;
      end else if (!wr_cl_vld_i && (|lo_req) && (starve_cnt_q != 8'(StarveLimit))) begin
         starve_cnt_d = starve_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) starve_cnt_q <= '0;
      else         starve_cnt_q <= starve_cnt_d;
   end
`else
   assign force_lo = 1'b0;
`endif

   always_comb begin
      hi_req  = rd_req_i & rd_prio_i;
      lo_req  = rd_req_i & ~rd_prio_i;
      use_lo  = ~(|hi_req) | force_lo;
      cls_req = use_lo ? lo_req : hi_req;
      ptr     = use_lo ? rr_lo_q : rr_hi_q;
      cand    = '0;
      gnt_idx = '0;
      found   = 1'b0;
      // first requester at or after the class pointer wins
      for (int unsigned i = 0; i < NumPorts; i++) begin
         cand = wrap_inc(ptr, i);
         if (!found && cls_req[cand]) begin
            found   = 1'b1;
            gnt_idx = cand;
         end
      end
      grant = found & ~wr_cl_vld_i;
   end

   always_comb begin
      rd_ack_o        = grant ? (NumPorts'(1) << gnt_idx) : '0;
      wr_ack_o        = wr_req_i & ~wr_cl_vld_i & ~(|rd_req_i);
      bank_we_o       = wr_ack_o;
      bank_req_o      = grant | wr_ack_o;
      bank_tag_only_o = grant & rd_tag_only_i[gnt_idx];
      bank_idx_o      = grant ? rd_idx_i[gnt_idx*IdxWidth +: IdxWidth] : '0;
      bank_off_o      = grant ? rd_off_i[gnt_idx*OffWidth +: OffWidth] : '0;
   end

   always_comb begin
      rr_hi_d   = rr_hi_q;
      rr_lo_d   = rr_lo_q;
      rd_vld_d  = grant;
      rd_port_d = rd_port_q;
      if (grant) begin
         rd_port_d = gnt_idx;
         if (use_lo) rr_lo_d = wrap_inc(gnt_idx, 1);
         else        rr_hi_d = wrap_inc(gnt_idx, 1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_hi_q   <= '0;
         rr_lo_q   <= '0;
         rd_vld_q  <= 1'b0;
         rd_port_q <= '0;
      end else begin
         rr_hi_q   <= rr_hi_d;
         rr_lo_q   <= rr_lo_d;
         rd_vld_q  <= rd_vld_d;
         rd_port_q <= rd_port_d;
      end
   end

   assign rd_vld_q_o  = rd_vld_q;
   assign rd_port_q_o = rd_port_q;

endmodule

// File: tb/tb_wt_dcache_rd_arb.sv
// Self-checking bench for wt_dcache_rd_arb: directed scenarios plus randomized traffic against
// a queue-free reference model of class priority, round-robin pointers and the starvation guard.
module tb_wt_dcache_rd_arb;
   localparam int NP    = 3;
   localparam int IW    = 8;
   localparam int OW    = 4;
   localparam int LIMIT = 8;
   localparam int NP5   = 5;
`ifdef WT_DCACHE_RD_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    rd_req = '0, rd_prio = '0, rd_tag = '0, rd_ack;
   logic [NP*IW-1:0] rd_idx = '0;
   logic [NP*OW-1:0] rd_off = '0;
   logic             wr_cl_vld = 1'b0, wr_req = 1'b0, wr_ack;
   logic             bank_req, bank_we, bank_tag_only, rd_vld_q;
   logic [IW-1:0]    bank_idx;
   logic [OW-1:0]    bank_off;
   logic [1:0]       rd_port_q;

   logic [NP5-1:0]    req5 = '0, prio5 = '0, tag5 = '0, ack5;
   logic [NP5*IW-1:0] idx5 = '0;
   logic [NP5*OW-1:0] off5 = '0;
   logic              wack5, breq5, bwe5, btag5, vld5;
   logic [IW-1:0]     bidx5;
   logic [OW-1:0]     boff5;
   logic [2:0]        port5;

   wt_dcache_rd_arb #(.NumPorts(NP), .IdxWidth(IW), .OffWidth(OW), .StarveLimit(LIMIT)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .rd_req_i(rd_req), .rd_prio_i(rd_prio), .rd_tag_only_i(rd_tag),
      .rd_idx_i(rd_idx), .rd_off_i(rd_off), .rd_ack_o(rd_ack), .wr_cl_vld_i(wr_cl_vld),
      .wr_req_i(wr_req), .wr_ack_o(wr_ack), .bank_req_o(bank_req), .bank_we_o(bank_we),
      .bank_tag_only_o(bank_tag_only), .bank_idx_o(bank_idx), .bank_off_o(bank_off),
      .rd_vld_q_o(rd_vld_q), .rd_port_q_o(rd_port_q));

   wt_dcache_rd_arb #(.NumPorts(NP5), .IdxWidth(IW), .OffWidth(OW), .StarveLimit(LIMIT)) u_dut5 (
      .clk_i(clk), .rst_ni(rst_n), .rd_req_i(req5), .rd_prio_i(prio5), .rd_tag_only_i(tag5),
      .rd_idx_i(idx5), .rd_off_i(off5), .rd_ack_o(ack5), .wr_cl_vld_i(1'b0),
      .wr_req_i(1'b0), .wr_ack_o(wack5), .bank_req_o(breq5), .bank_we_o(bwe5),
      .bank_tag_only_o(btag5), .bank_idx_o(bidx5), .bank_off_o(boff5),
      .rd_vld_q_o(vld5), .rd_port_q_o(port5));

   int n_vec = 0;
   int n_err = 0;
   int hi_ptr = 0, lo_ptr = 0, starve = 0, m_port = 0, m_g = -1;
   bit m_vld = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NP-1:0] msk, input int ptr);
      for (int k = 0; k < NP; k++) if (msk[(ptr + k) % NP]) return (ptr + k) % NP;
      return -1;
   endfunction

   task automatic model_reset();
      hi_ptr = 0; lo_ptr = 0; starve = 0; m_port = 0; m_vld = 1'b0; m_g = -1;
   endtask

   // one arbitration cycle: drive, check outputs against the model, advance the model
   task automatic step(input logic [NP-1:0] req, input logic [NP-1:0] prio, input logic [NP-1:0] tag,
                       input logic wcl, input logic wreq);
      logic [NP-1:0] hi, lo;
      bit force_lo, use_lo, wack;
      int g;
      @(negedge clk);
      rd_req = req; rd_prio = prio; rd_tag = tag; wr_cl_vld = wcl; wr_req = wreq;
      rd_idx = (NP*IW)'($urandom);
      rd_off = (NP*OW)'($urandom);
      #1;
      chk("rd_vld_q", 32'(rd_vld_q), 32'(m_vld));
      chk("rd_port_q", 32'(rd_port_q), m_port);
      hi = req & prio;
      lo = req & ~prio;
      force_lo = GUARD && (starve == LIMIT) && (lo != 0);
      use_lo = (hi == 0) || force_lo;
      g = wcl ? -1 : pick(use_lo ? lo : hi, use_lo ? lo_ptr : hi_ptr);
      wack = wreq && !wcl && (req == 0);
      chk("rd_ack", 32'(rd_ack), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("wr_ack", 32'(wr_ack), 32'(wack));
      chk("bank_req", 32'(bank_req), 32'((g >= 0) || wack));
      chk("bank_we", 32'(bank_we), 32'(wack));
      chk("bank_tag_only", 32'(bank_tag_only), (g >= 0) ? 32'(tag[g]) : 32'd0);
      chk("bank_idx", 32'(bank_idx), (g >= 0) ? 32'((rd_idx >> (g * IW)) & 24'hff) : 32'd0);
      chk("bank_off", 32'(bank_off), (g >= 0) ? 32'((rd_off >> (g * OW)) & 12'hf) : 32'd0);
      m_g = g;
      if (g >= 0 && use_lo) begin
         lo_ptr = (g + 1) % NP;
         starve = 0;
      end else begin
         if (g >= 0) hi_ptr = (g + 1) % NP;
         if (!wcl && lo != 0 && starve < LIMIT) starve++;
      end
      m_vld = (g >= 0);
      if (g >= 0) m_port = g;
   endtask

   // asynchronous reset asserted between clock edges
   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      rd_req = '0; rd_prio = '0; rd_tag = '0; wr_cl_vld = 1'b0; wr_req = 1'b0;
      #1;
      chk("rst_vld_q", 32'(rd_vld_q), 32'd0);
      chk("rst_port_q", 32'(rd_port_q), 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp;
      repeat (2) @(negedge clk);
      #1;
      chk("init_vld_q", 32'(rd_vld_q), 32'd0);
      chk("init_port_q", 32'(rd_port_q), 32'd0);
      chk("init_ack", 32'(rd_ack), 32'd0);
      chk("init_bank_req", 32'(bank_req), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // five all-high requesters rotate 0..4 then wrap
      @(negedge clk);
      req5 = '1; prio5 = '1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk("t5_ack", 32'(ack5), 32'd1 << (k % NP5));
         if (k > 0) chk("t5_port_q", 32'(port5), (k - 1) % NP5);
         @(negedge clk);
      end
      req5 = '0;

      // two high-prio ports alternate
      for (int k = 0; k < 4; k++) begin
         step(3'b011, 3'b011, 3'b010, 1'b0, 1'b0);
         chk("t1_ack", 32'(rd_ack), (k % 2) ? 32'd2 : 32'd1);
      end

      // line refill blocks everything, pointers hold
      step(3'b111, 3'b011, 3'b000, 1'b1, 1'b1);
      chk("t2_blk_ack", 32'(rd_ack), 32'd0);
      step(3'b111, 3'b011, 3'b000, 1'b1, 1'b0);
      step(3'b111, 3'b011, 3'b101, 1'b0, 1'b0);
      chk("t2_resume", 32'(rd_ack), 32'd1);

      // word write only wins with no readers
      step(3'b000, 3'b000, 3'b000, 1'b0, 1'b1);
      chk("t3_wr_ack", 32'(wr_ack), 32'd1);
      step(3'b100, 3'b000, 3'b100, 1'b0, 1'b1);
      chk("t3_rd_wins", 32'(rd_ack), 32'd4);

      // starvation scenario from a clean state
      reset_mid();
      for (int k = 0; k < 12; k++) begin
         step(3'b111, 3'b011, 3'b000, 1'b0, 1'b0);
`ifdef WT_DCACHE_RD_ARB_STARVE_GUARD_EN
         exp = (k == 8) ? 4 : ((((k < 8) ? k : k - 1) % 2) ? 2 : 1);
`else
         exp = (k % 2) ? 2 : 1;
`endif
         chk("t4_ack", 32'(rd_ack), exp);
      end

      // reset right after a grant to port 2
      step(3'b100, 3'b100, 3'b000, 1'b0, 1'b0);
      step(3'b000, 3'b000, 3'b000, 1'b0, 1'b0);
      chk("t6_vld_before", 32'(rd_vld_q), 32'd1);
      chk("t6_port_before", 32'(rd_port_q), 32'd2);
      reset_mid();
      step(3'b111, 3'b111, 3'b000, 1'b0, 1'b0);
      chk("t6_first", 32'(rd_ack), 32'd1);

      // randomized traffic
      for (int k = 0; k < 300; k++) begin
         step(NP'($urandom), NP'($urandom), NP'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
